// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the keypad event-capture path.
//               FSM state encoding, scanner key-code constants and the
//               default parameter values used by key_event_capture.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Event-capture FSM state encoding
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kec_state_t;

    // Key codes as produced by the row scanner
    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;

    // Default parameter values
    localparam int c_DEBOUNCE_CYCLES = 4;
    localparam int c_RELEASE_CYCLES  = 4;
    localparam int c_FIFO_DEPTH      = 4;
    localparam int c_REPEAT_DELAY    = 64;
    localparam int c_REPEAT_RATE     = 16;

endpackage
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_fifo
// Description : Synchronous FIFO, FIFO_DEPTH entries x 4 bits, for key events.
//               A push into a full queue is accepted only if a pop happens in
//               the same cycle; otherwise it is dropped and o_overflow pulses
//               for one cycle. Pops on an empty queue are ignored.
// Ports       : clk, rst_n (async, active low)
//               i_push/i_data  - write request and key code
//               i_pop          - read request (gated internally by not-empty)
//               o_data         - head entry, o_valid - not empty
//               o_count        - occupancy, o_overflow - drop pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_push,
    input  logic [3:0]                        i_data,
    input  logic                              i_pop,
    output logic [3:0]                        o_data,
    output logic                              o_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count,
    output logic                              o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [3:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A simultaneous pop frees the slot the push needs, so full+pop+push is legal
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_push & w_full & ~w_do_pop;
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                // Depth is a power of two, so the pointer wraps naturally
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_valid    = ~w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/key_event_capture.sv
`default_nettype none
// ============================================================================
// Module      : key_event_capture
// Description : Debounces the keypad scanner output, holds the column scan
//               while a key is being qualified or held, and queues one 4-bit
//               event per accepted press for a valid/ready consumer.
//               Optional auto-repeat is built when KEYPAD_REPEAT_EN is defined.
// Ports       : slow_clk    - scan clock (rising edge)
//               rst         - asynchronous reset, active low
//               key_pressed - any row active, key_value - scanner key code
//               scan_hold   - freeze column shift register (combinational)
//               key_out/key_valid/key_ready - event handshake (FIFO head)
//               key_count   - queue occupancy, overflow - event-drop pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_capture
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES,
    parameter int RELEASE_CYCLES  = c_RELEASE_CYCLES,
    parameter int FIFO_DEPTH      = c_FIFO_DEPTH,
    parameter int REPEAT_DELAY    = c_REPEAT_DELAY,
    parameter int REPEAT_RATE     = c_REPEAT_RATE
) (
    input  logic                              slow_clk,
    input  logic                              rst,
    input  logic                              key_pressed,
    input  logic [3:0]                        key_value,
    output logic                              scan_hold,
    output logic [3:0]                        key_out,
    output logic                              key_valid,
    input  logic                              key_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   key_count,
    output logic                              overflow
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (DEBOUNCE_CYCLES < 2 || RELEASE_CYCLES < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("key_event_capture: illegal parameter set");
    end

    kec_state_t       r_state;
    kec_state_t       w_state_nxt;
    logic [3:0]       r_cand;
    logic [3:0]       w_cand_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_match;
    logic             w_push_db;
    logic             w_push;

    assign w_match   = key_pressed & (key_value == r_cand);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cand  <= KEY_0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_push_db   = 1'b0;
        case (r_state)
            IDLE: begin
                if (key_pressed) begin
                    w_cand_nxt  = key_value;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (w_match) begin
                    // r_cnt counts samples already matched; this one completes the run
                    if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        w_push_db   = 1'b1;
                        w_state_nxt = PRESSED;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PRESSED: begin
                // A different code while held is ignored: no rollover
                if (!key_pressed) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = (RELEASE_CYCLES == 1) ? IDLE : RELEASE;
                end
            end
            RELEASE: begin
                if (key_pressed) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == CNT_W'(RELEASE_CYCLES - 1)) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_rep_armed;   // first repeat already issued: use REPEAT_RATE
    logic             w_rep_hold;
    logic             w_rep_hit;

    // Only a held key that stays in PRESSED advances the repeat timer; any
    // exit (including a bounce into RELEASE) restarts it from zero.
    assign w_rep_hold = (r_state == PRESSED) & key_pressed;
    assign w_rep_hit  = w_rep_hold &
                        (r_rep_cnt == (r_rep_armed ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1)));

    always_ff @(posedge slow_clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (!w_rep_hold) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_hit) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
        end else begin
            r_rep_cnt   <= r_rep_cnt + REP_W'(1);
        end
    end

    assign w_push = w_push_db | w_rep_hit;
`else
    assign w_push = w_push_db;
`endif

    // Freeze the columns on the very first active sample, before the FSM moves
    assign scan_hold = (r_state != IDLE) | key_pressed;

    key_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clk        (slow_clk),
        .rst_n      (rst),
        .i_push     (w_push),
        .i_data     (r_cand),
        .i_pop      (key_ready),
        .o_data     (key_out),
        .o_valid    (key_valid),
        .o_count    (key_count),
        .o_overflow (overflow)
    );

endmodule
`default_nettype wire
